rx_byte_frame_buf: RTL

RX_BYTE_FRAME_BUF -- requirements
Module: rx_byte_frame_buf

---
 rtl/rx_byte_frame_buf_if.sv | 33 +++
 rtl/rx_byte_frame_buf.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_frame_buf_if.sv
// Write-word / read-byte bundle for the frame buffer.
// slave = the buffer, master = the producer/consumer side.
interface rx_byte_frame_buf_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 12
);
    localparam int LB_W = $clog2(DATA_W / 8) + 1;

    logic              wr_valid;
    logic              wr_sof;
    logic              wr_eof;
    logic [LB_W-1:0]   wr_last_bytes;
    logic              wr_ok;
    logic [DATA_W-1:0] wr_data;

    logic              rd_frame_avail;
    logic [LEN_W-1:0]  rd_frame_len;
    logic              rd_valid;
    logic              rd_ready;
    logic [7:0]        rd_data;
    logic              rd_last;
    logic [15:0]       drop_cnt;

    modport slave (
        input  wr_valid, wr_sof, wr_eof, wr_last_bytes, wr_ok, wr_data, rd_ready,
        output rd_frame_avail, rd_frame_len, rd_valid, rd_data, rd_last, drop_cnt
    );

    modport master (
        output wr_valid, wr_sof, wr_eof, wr_last_bytes, wr_ok, wr_data, rd_ready,
        input  rd_frame_avail, rd_frame_len, rd_valid, rd_data, rd_last, drop_cnt
    );
endinterface

// File: rtl/rx_byte_frame_buf.sv
// Word-in / byte-out receive frame buffer: frames are committed or discarded at eof,
// committed frames are streamed out byte by byte with their length known up front.
module rx_byte_frame_buf #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 768,
    parameter int MAX_FRAMES = 4,
    parameter int LEN_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    rx_byte_frame_buf_if.slave bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int DW     = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam int DCW    = $clog2(MAX_FRAMES + 1);
    localparam int BW     = LEN_W + 1;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MAXLEN = (2 ** LEN_W) - 1;

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP}    wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

    function automatic logic [AW-1:0] ainc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [DW-1:0] dinc(input logic [DW-1:0] p);
        return (p == DW'(MAX_FRAMES - 1)) ? '0 : p + 1'b1;
    endfunction

    // storage
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_ram_q;

    // write side
    wstate_t           r_ws;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_wcommit;
    logic [CW-1:0]     r_frm_words;
    logic [BW-1:0]     r_byte_cnt;
    logic [CW-1:0]     r_commit_used;
    logic [15:0]       r_drop;

    // descriptor fifo
    logic [LEN_W-1:0]  r_dlen   [MAX_FRAMES];
    logic [CW-1:0]     r_dwords [MAX_FRAMES];
    logic [DW-1:0]     r_dhead;
    logic [DW-1:0]     r_dtail;
    logic [DCW-1:0]    r_dcnt;

    // read side
    rstate_t           r_rs;
    logic [AW-1:0]     r_rel_ptr;
    logic [AW-1:0]     r_rd_addr;
    logic [LANE_W-1:0] r_lane;
    logic [LEN_W-1:0]  r_left;
    logic              r_last;

    logic              w_start, w_live, w_fit, w_we, w_commit, w_dfull;
    logic              w_abort, w_drop_eof;
    logic [1:0]        w_ndrop;
    logic [16:0]       w_drop_sum;
    logic [BW-1:0]     w_wb, w_cur_bytes, w_new_bytes;
    logic [CW-1:0]     w_cur_words, w_head_words;
    logic [CW:0]       w_used;
    logic [AW-1:0]     w_cur_ptr, w_ptr_inc, w_raddr;
    logic [CW-1:0]     w_rel_sum;
    logic              w_xfer, w_pop, w_ren;
    logic [BYTES-1:0][7:0] w_qb;

    // a sof restarts the frame from the committed pointer, whatever state we are in
    assign w_start     = bus.wr_valid & bus.wr_sof;
    assign w_live      = w_start | (r_ws == W_RECV);
    assign w_cur_words = w_start ? '0 : r_frm_words;
    assign w_cur_bytes = w_start ? '0 : r_byte_cnt;
    assign w_cur_ptr   = w_start ? r_wcommit : r_wr_ptr;
    assign w_ptr_inc   = ainc(w_cur_ptr);
    assign w_wb        = bus.wr_eof ? BW'(bus.wr_last_bytes) : BW'(BYTES);
    assign w_new_bytes = w_cur_bytes + w_wb;
    assign w_used      = {1'b0, r_commit_used} + {1'b0, w_cur_words};
    assign w_fit       = (w_used < (CW+1)'(DEPTH)) && (w_new_bytes <= BW'(MAXLEN));
    assign w_we        = bus.wr_valid & w_live & w_fit;
    assign w_dfull     = (r_dcnt == DCW'(MAX_FRAMES));
    assign w_commit    = w_we & bus.wr_eof & bus.wr_ok & ~w_dfull;
    assign w_abort     = w_start & (r_ws != W_IDLE);
    assign w_drop_eof  = bus.wr_valid & bus.wr_eof &
                         ((w_live & ~w_commit) | ((r_ws == W_DROP) & ~w_start));
    assign w_ndrop     = {1'b0, w_abort} + {1'b0, w_drop_eof};
    assign w_drop_sum  = {1'b0, r_drop} + 17'(w_ndrop);

    assign w_head_words = r_dwords[r_dhead];
    assign w_xfer      = (r_rs == R_STREAM) & bus.rd_ready;
    assign w_pop       = w_xfer & r_last;
    // the next word is read on the edge that consumes the current word's last lane,
    // so it lands in r_ram_q exactly when lane 0 is needed
    assign w_ren       = (r_rs == R_FETCH) |
                         (w_xfer & ~r_last & (r_lane == LANE_W'(BYTES - 1)));
    assign w_raddr     = (r_rs == R_FETCH) ? r_rel_ptr : r_rd_addr;
    assign w_rel_sum   = {1'b0, r_rel_ptr} + w_head_words;
    assign w_qb        = r_ram_q;

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_cur_ptr] <= bus.wr_data;
        if (w_ren)
            r_ram_q <= r_mem[w_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ws        <= W_IDLE;
            r_wr_ptr    <= '0;
            r_wcommit   <= '0;
            r_frm_words <= '0;
            r_byte_cnt  <= '0;
            r_drop      <= '0;
        end else begin
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (bus.wr_valid) begin
                if (w_live) begin
                    if (w_commit) begin
                        r_wcommit   <= w_ptr_inc;
                        r_wr_ptr    <= w_ptr_inc;
                        r_frm_words <= '0;
                        r_byte_cnt  <= '0;
                        r_ws        <= W_IDLE;
                    end else if (bus.wr_eof) begin
                        r_wr_ptr    <= r_wcommit;
                        r_frm_words <= '0;
                        r_byte_cnt  <= '0;
                        r_ws        <= W_IDLE;
                    end else if (w_fit) begin
                        r_wr_ptr    <= w_ptr_inc;
                        r_frm_words <= w_cur_words + 1'b1;
                        r_byte_cnt  <= w_new_bytes;
                        r_ws        <= W_RECV;
                    end else begin
                        r_wr_ptr    <= r_wcommit;
                        r_frm_words <= '0;
                        r_byte_cnt  <= '0;
                        r_ws        <= W_DROP;
                    end
                end else if ((r_ws == W_DROP) && bus.wr_eof) begin
                    r_ws <= W_IDLE;
                end
            end
        end
    end

    // descriptor fifo and occupancy; commit and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dhead       <= '0;
            r_dtail       <= '0;
            r_dcnt        <= '0;
            r_commit_used <= '0;
            r_rel_ptr     <= '0;
        end else begin
            if (w_commit) begin
                r_dlen[r_dtail]   <= w_new_bytes[LEN_W-1:0];
                r_dwords[r_dtail] <= w_cur_words + 1'b1;
                r_dtail           <= dinc(r_dtail);
            end
            if (w_pop) begin
                r_dhead   <= dinc(r_dhead);
                r_rel_ptr <= (w_rel_sum >= CW'(DEPTH)) ? AW'(w_rel_sum - CW'(DEPTH))
                                                       : w_rel_sum[AW-1:0];
            end
            case ({w_commit, w_pop})
                2'b10:   r_dcnt <= r_dcnt + 1'b1;
                2'b01:   r_dcnt <= r_dcnt - 1'b1;
                default: r_dcnt <= r_dcnt;
            endcase
            r_commit_used <= r_commit_used
                           + (w_commit ? (w_cur_words + 1'b1) : '0)
                           - (w_pop ? w_head_words : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs      <= R_IDLE;
            r_rd_addr <= '0;
            r_lane    <= '0;
            r_left    <= '0;
            r_last    <= 1'b0;
        end else begin
            case (r_rs)
                R_IDLE: begin
                    if (r_dcnt != '0)
                        r_rs <= R_FETCH;
                end
                R_FETCH: begin
                    r_rs      <= R_STREAM;
                    r_rd_addr <= ainc(r_rel_ptr);
                    r_lane    <= '0;
                    r_left    <= r_dlen[r_dhead];
                    r_last    <= (r_dlen[r_dhead] == LEN_W'(1));
                end
                R_STREAM: begin
                    if (bus.rd_ready) begin
                        if (r_last) begin
                            r_rs   <= R_IDLE;
                            r_last <= 1'b0;
                        end else begin
                            r_left <= r_left - 1'b1;
                            r_last <= (r_left == LEN_W'(2));
                            if (r_lane == LANE_W'(BYTES - 1)) begin
                                r_lane    <= '0;
                                r_rd_addr <= ainc(r_rd_addr);
                            end else begin
                                r_lane <= r_lane + 1'b1;
                            end
                        end
                    end
                end
                default: r_rs <= R_IDLE;
            endcase
        end
    end

    assign bus.rd_frame_avail = (r_dcnt != '0);
    assign bus.rd_frame_len   = (r_dcnt != '0) ? r_dlen[r_dhead] : '0;
    assign bus.rd_valid       = (r_rs == R_STREAM);
    assign bus.rd_data        = (r_rs == R_STREAM) ? w_qb[r_lane] : 8'h00;
    assign bus.rd_last        = (r_rs == R_STREAM) & r_last;
    assign bus.drop_cnt       = r_drop;
endmodule
